// File: rtl/hps_pio_cmd_bridge.sv
// Bridge between the HPS parallel-I/O handshake exports and the coprocessor core.
// Commands and results are buffered in FIFOs; the PIO side uses a four-phase handshake.
module hps_pio_cmd_bridge #(
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 8,
  parameter int RES_DEPTH = 4,
  parameter int SYNC_IN   = 0
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic [DATA_W-1:0]            instrucao,
  input  logic [1:0]                   act_ins,
  output logic [1:0]                   wait_s,
  output logic [DATA_W-1:0]            data,
  output logic [DATA_W-1:0]            cmd_data,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  input  logic [DATA_W-1:0]            res_data,
  input  logic                         res_valid,
  output logic                         res_ready,
  output logic [$clog2(CMD_DEPTH):0]   cmd_level,
  output logic [$clog2(RES_DEPTH):0]   res_level
);

  localparam int CMD_AW = $clog2(CMD_DEPTH);
  localparam int RES_AW = $clog2(RES_DEPTH);
  localparam logic [CMD_AW:0] CMD_ONE = (CMD_AW+1)'(1);
  localparam logic [RES_AW:0] RES_ONE = (RES_AW+1)'(1);

  typedef enum logic {CI_IDLE, CI_ACK} ci_state_t;
  typedef enum logic [1:0] {R_EMPTY, R_PRESENT, R_DRAIN} r_state_t;

  logic [1:0] act;

  generate
    if (SYNC_IN != 0) begin : g_sync
      logic [1:0] sync_q1;
      logic [1:0] sync_q2;
      always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
          sync_q1 <= '0;
          sync_q2 <= '0;
        end else begin
          sync_q1 <= act_ins;
          sync_q2 <= sync_q1;
        end
      end
      assign act = sync_q2;
    end else begin : g_nosync
      assign act = act_ins;
    end
  endgenerate

  logic [DATA_W-1:0] cmd_mem [CMD_DEPTH];
  logic [CMD_AW:0]   cmd_wptr, cmd_rptr, cmd_wptr_nxt, cmd_rptr_nxt;
  logic              cmd_full, cmd_push, cmd_pop;

  logic [DATA_W-1:0] res_mem [RES_DEPTH];
  logic [RES_AW:0]   res_wptr, res_rptr, res_wptr_nxt, res_rptr_nxt;
  logic              res_empty, res_push, res_pop, data_load;

  ci_state_t ci_state, ci_next;
  r_state_t  r_state, r_next;

  assign cmd_full = (cmd_wptr[CMD_AW-1:0] == cmd_rptr[CMD_AW-1:0]) &&
                    (cmd_wptr[CMD_AW] != cmd_rptr[CMD_AW]);
  assign cmd_pop  = cmd_valid & cmd_ready;
  assign cmd_data = cmd_mem[cmd_rptr[CMD_AW-1:0]];

  assign res_empty = (res_wptr == res_rptr);
  assign res_push  = res_valid & res_ready;

  assign cmd_wptr_nxt = cmd_push ? cmd_wptr + CMD_ONE : cmd_wptr;
  assign cmd_rptr_nxt = cmd_pop  ? cmd_rptr + CMD_ONE : cmd_rptr;
  assign res_wptr_nxt = res_push ? res_wptr + RES_ONE : res_wptr;
  assign res_rptr_nxt = res_pop  ? res_rptr + RES_ONE : res_rptr;

  assign wait_s = {r_state == R_PRESENT, ci_state == CI_ACK};

  // One push per request phase: the ACK state blocks re-pushing until a[0] drops.
  always_comb begin
    ci_next  = ci_state;
    cmd_push = 1'b0;
    case (ci_state)
      CI_IDLE: begin
        if (act[0] && !cmd_full) begin
          cmd_push = 1'b1;
          ci_next  = CI_ACK;
        end
      end
      CI_ACK: begin
        if (!act[0]) ci_next = CI_IDLE;
      end
      default: ci_next = CI_IDLE;
    endcase
  end

  // The presented word stays in the FIFO until the HPS acknowledges it.
  always_comb begin
    r_next    = r_state;
    res_pop   = 1'b0;
    data_load = 1'b0;
    case (r_state)
      R_EMPTY: begin
        if (!res_empty) begin
          data_load = 1'b1;
          r_next    = R_PRESENT;
        end
      end
      R_PRESENT: begin
        if (act[1]) begin
          res_pop = 1'b1;
          r_next  = R_DRAIN;
        end
      end
      R_DRAIN: begin
        if (!act[1]) r_next = R_EMPTY;
      end
      default: r_next = R_EMPTY;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ci_state <= CI_IDLE;
      r_state  <= R_EMPTY;
      data     <= '0;
    end else begin
      ci_state <= ci_next;
      r_state  <= r_next;
      if (data_load) data <= res_mem[res_rptr[RES_AW-1:0]];
    end
  end

  // Status outputs are registered from the post-edge pointer values.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cmd_wptr  <= '0;
      cmd_rptr  <= '0;
      cmd_valid <= 1'b0;
      cmd_level <= '0;
      res_wptr  <= '0;
      res_rptr  <= '0;
      res_ready <= 1'b1;
      res_level <= '0;
    end else begin
      cmd_wptr  <= cmd_wptr_nxt;
      cmd_rptr  <= cmd_rptr_nxt;
      cmd_valid <= (cmd_wptr_nxt != cmd_rptr_nxt);
      cmd_level <= cmd_wptr_nxt - cmd_rptr_nxt;
      res_wptr  <= res_wptr_nxt;
      res_rptr  <= res_rptr_nxt;
      res_ready <= !((res_wptr_nxt[RES_AW-1:0] == res_rptr_nxt[RES_AW-1:0]) &&
                     (res_wptr_nxt[RES_AW] != res_rptr_nxt[RES_AW]));
      res_level <= res_wptr_nxt - res_rptr_nxt;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (cmd_push) cmd_mem[cmd_wptr[CMD_AW-1:0]] <= instrucao;
    if (res_push) res_mem[res_wptr[RES_AW-1:0]] <= res_data;
  end

endmodule

// File: tb/tb_hps_pio_cmd_bridge.sv
// Scoreboard bench for hps_pio_cmd_bridge; a second SYNC_IN=1 instance shares the stimulus
// so the synchroniser delay can be measured against the direct one.
module tb_hps_pio_cmd_bridge;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [31:0] instrucao, res_data;
  logic [1:0]  act_ins;
  logic        cmd_ready, res_valid;

  logic [1:0]  wait_s, s_wait_s;
  logic [31:0] data, cmd_data, s_data, s_cmd_data;
  logic        cmd_valid, res_ready, s_cmd_valid, s_res_ready;
  logic [3:0]  cmd_level, s_cmd_level;
  logic [2:0]  res_level, s_res_level;

  int n_checks = 0;
  int n_fail   = 0;
  bit ok;
  logic [31:0] cmd_q[$];
  logic [31:0] res_q[$];

  hps_pio_cmd_bridge #(.DATA_W(32), .CMD_DEPTH(8), .RES_DEPTH(4), .SYNC_IN(0)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .instrucao(instrucao), .act_ins(act_ins),
    .wait_s(wait_s), .data(data), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .cmd_level(cmd_level), .res_level(res_level));

  hps_pio_cmd_bridge #(.DATA_W(32), .CMD_DEPTH(8), .RES_DEPTH(4), .SYNC_IN(1)) dut_sync (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .instrucao(instrucao), .act_ins(act_ins),
    .wait_s(s_wait_s), .data(s_data), .cmd_data(s_cmd_data), .cmd_valid(s_cmd_valid),
    .cmd_ready(cmd_ready), .res_data(res_data), .res_valid(res_valid), .res_ready(s_res_ready),
    .cmd_level(s_cmd_level), .res_level(s_res_level));

  always #5 clk_clk = ~clk_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  // Command pops are scored just before the edge that performs them.
  always @(negedge clk_clk) begin
    if (!reset_reset && cmd_valid && cmd_ready) begin
      if (cmd_q.size() == 0) checkOutput("cmd_underflow", 32'(cmd_q.size()), 32'd1);
      else checkOutput("cmd_order", cmd_data, cmd_q.pop_front());
    end
  end

  task automatic hps_write(input logic [31:0] word, output bit acked);
    instrucao  = word;
    act_ins[0] = 1'b1;
    acked      = 1'b0;
    for (int i = 0; i < 20 && !acked; i++) begin
      step(1);
      if (wait_s[0] === 1'b1) acked = 1'b1;
    end
    if (acked) cmd_q.push_back(word);
    act_ins[0] = 1'b0;
    for (int i = 0; i < 20 && wait_s[0] !== 1'b0; i++) step(1);
    checkOutput("write_release", 32'(wait_s[0]), 32'd0);
  endtask

  task automatic hps_read();
    logic [31:0] exp_word;
    for (int i = 0; i < 20 && wait_s[1] !== 1'b1; i++) step(1);
    if (wait_s[1] !== 1'b1) begin
      checkOutput("read_timeout", 32'(wait_s[1]), 32'd1);
      return;
    end
    if (res_q.size() == 0) begin
      checkOutput("res_underflow", 32'(res_q.size()), 32'd1);
      return;
    end
    exp_word = res_q.pop_front();
    checkOutput("read_data", data, exp_word);
    step(2);
    checkOutput("read_hold", data, exp_word);
    checkOutput("read_valid_hold", 32'(wait_s[1]), 32'd1);
    act_ins[1] = 1'b1;
    step(1);
    checkOutput("read_ack", 32'(wait_s[1]), 32'd0);
    act_ins[1] = 1'b0;
    step(1);
  endtask

  task automatic drain_cmds();
    cmd_ready = 1'b1;
    for (int i = 0; i < 40 && cmd_valid; i++) step(1);
    cmd_ready = 1'b0;
    checkOutput("drain_valid", 32'(cmd_valid), 32'd0);
    checkOutput("drain_level", 32'(cmd_level), 32'd0);
    checkOutput("drain_queue", 32'(cmd_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_reset = 1'b1;
    instrucao   = '0;
    res_data    = '0;
    act_ins     = 2'b00;
    cmd_ready   = 1'b0;
    res_valid   = 1'b0;
    step(2);
    checkOutput("rst_wait", 32'(wait_s), 32'd0);
    checkOutput("rst_data", data, 32'd0);
    checkOutput("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    checkOutput("rst_res_ready", 32'(res_ready), 32'd1);
    checkOutput("rst_cmd_level", 32'(cmd_level), 32'd0);
    checkOutput("rst_res_level", 32'(res_level), 32'd0);
    reset_reset = 1'b0;
    step(1);

    // Single command, request held for ten cycles
    instrucao = 32'hA5A5_0001;
    act_ins   = 2'b01;
    checkOutput("single_pre_ack", 32'(wait_s[0]), 32'd0);
    step(1);
    checkOutput("single_ack", 32'(wait_s[0]), 32'd1);
    checkOutput("single_valid", 32'(cmd_valid), 32'd1);
    checkOutput("single_level", 32'(cmd_level), 32'd1);
    checkOutput("single_data", cmd_data, 32'hA5A5_0001);
    checkOutput("sync_ack_c1", 32'(s_wait_s[0]), 32'd0);
    cmd_q.push_back(32'hA5A5_0001);
    step(1);
    checkOutput("sync_ack_c2", 32'(s_wait_s[0]), 32'd0);
    step(1);
    checkOutput("sync_ack_c3", 32'(s_wait_s[0]), 32'd1);
    step(7);
    checkOutput("single_one_push", 32'(cmd_level), 32'd1);
    checkOutput("sync_one_push", 32'(s_cmd_level), 32'd1);
    act_ins = 2'b00;
    step(1);
    checkOutput("single_release", 32'(wait_s[0]), 32'd0);
    checkOutput("sync_rel_c1", 32'(s_wait_s[0]), 32'd1);
    step(1);
    checkOutput("sync_rel_c2", 32'(s_wait_s[0]), 32'd1);
    step(1);
    checkOutput("sync_rel_c3", 32'(s_wait_s[0]), 32'd0);
    drain_cmds();

    // Full back-pressure with the coprocessor stalled
    for (int i = 0; i < 8; i++) begin
      hps_write(32'hB000_0000 + 32'(i), ok);
      checkOutput("bp_ack", 32'(ok), 32'd1);
    end
    checkOutput("bp_level8", 32'(cmd_level), 32'd8);
    instrucao  = 32'hB000_0009;
    act_ins[0] = 1'b1;
    step(3);
    checkOutput("bp_ninth_held", 32'(wait_s[0]), 32'd0);
    checkOutput("bp_level_held", 32'(cmd_level), 32'd8);
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    checkOutput("bp_pop_no_push", 32'(wait_s[0]), 32'd0);
    checkOutput("bp_level7", 32'(cmd_level), 32'd7);
    step(1);
    checkOutput("bp_ninth_ack", 32'(wait_s[0]), 32'd1);
    checkOutput("bp_level_back", 32'(cmd_level), 32'd8);
    cmd_q.push_back(32'hB000_0009);
    act_ins[0] = 1'b0;
    step(1);
    checkOutput("bp_ninth_rel", 32'(wait_s[0]), 32'd0);
    drain_cmds();

    // Result stream, back-to-back pushes
    res_valid = 1'b1;
    res_data  = 32'd1;
    res_q.push_back(32'd1);
    step(1);
    checkOutput("res_lat_n", 32'(wait_s[1]), 32'd0);
    res_data = 32'd2;
    res_q.push_back(32'd2);
    step(1);
    checkOutput("res_lat_n1", 32'(wait_s[1]), 32'd1);
    checkOutput("res_lat_data", data, 32'd1);
    res_data = 32'd3;
    res_q.push_back(32'd3);
    step(1);
    res_valid = 1'b0;
    checkOutput("res_level3", 32'(res_level), 32'd3);
    for (int i = 0; i < 3; i++) hps_read();
    checkOutput("res_level0", 32'(res_level), 32'd0);
    checkOutput("res_q_empty", 32'(res_q.size()), 32'd0);

    // Result FIFO full, then simultaneous events
    for (int i = 0; i < 4; i++) begin
      checkOutput("full_fill_ready", 32'(res_ready), 32'd1);
      res_valid = 1'b1;
      res_data  = 32'h11 + 32'(i);
      res_q.push_back(32'h11 + 32'(i));
      step(1);
    end
    checkOutput("full_ready", 32'(res_ready), 32'd0);
    checkOutput("full_level", 32'(res_level), 32'd4);
    res_data = 32'hDEAD;
    step(1);
    checkOutput("full_blocked", 32'(res_level), 32'd4);
    checkOutput("full_present", data, res_q.pop_front());
    instrucao = 32'hC0DE_0001;
    res_data  = 32'h55;
    act_ins   = 2'b11;
    step(1);
    checkOutput("simul_cmd_level", 32'(cmd_level), 32'd1);
    checkOutput("simul_wait", 32'(wait_s), 32'd1);
    checkOutput("simul_res_level", 32'(res_level), 32'd3);
    checkOutput("simul_res_ready", 32'(res_ready), 32'd1);
    cmd_q.push_back(32'hC0DE_0001);
    res_valid = 1'b0;
    act_ins   = 2'b00;
    step(2);
    checkOutput("simul_next_present", 32'(wait_s), 32'd2);
    checkOutput("simul_next_data", data, res_q.pop_front());
    act_ins[1] = 1'b1;
    res_valid  = 1'b1;
    res_data   = 32'h66;
    step(1);
    res_q.push_back(32'h66);
    res_valid  = 1'b0;
    act_ins[1] = 1'b0;
    checkOutput("pushpop_res_level", 32'(res_level), 32'd3);
    checkOutput("pushpop_res_ack", 32'(wait_s[1]), 32'd0);
    instrucao  = 32'hC0DE_0002;
    act_ins[0] = 1'b1;
    cmd_ready  = 1'b1;
    step(1);
    cmd_q.push_back(32'hC0DE_0002);
    cmd_ready  = 1'b0;
    act_ins[0] = 1'b0;
    checkOutput("pushpop_cmd_level", 32'(cmd_level), 32'd1);
    checkOutput("pushpop_cmd_ack", 32'(wait_s[0]), 32'd1);
    step(1);
    for (int i = 0; i < 3; i++) hps_read();
    checkOutput("full_drained", 32'(res_level), 32'd0);
    drain_cmds();

    // Asynchronous reset with commands queued
    for (int i = 0; i < 3; i++) begin
      hps_write(32'hD000_0000 + 32'(i), ok);
      checkOutput("rst_q_ack", 32'(ok), 32'd1);
    end
    res_valid = 1'b1;
    res_data  = 32'h77;
    step(1);
    res_valid = 1'b0;
    step(2);
    checkOutput("rst_pre_level", 32'(cmd_level), 32'd3);
    checkOutput("rst_pre_wait", 32'(wait_s[1]), 32'd1);
    @(posedge clk_clk);
    #3;
    reset_reset = 1'b1;
    #1;
    cmd_q.delete();
    res_q.delete();
    checkOutput("arst_wait", 32'(wait_s), 32'd0);
    checkOutput("arst_data", data, 32'd0);
    checkOutput("arst_cmd_valid", 32'(cmd_valid), 32'd0);
    checkOutput("arst_res_ready", 32'(res_ready), 32'd1);
    checkOutput("arst_cmd_level", 32'(cmd_level), 32'd0);
    checkOutput("arst_res_level", 32'(res_level), 32'd0);
    step(1);
    reset_reset = 1'b0;
    step(2);
    checkOutput("post_rst_level", 32'(cmd_level), 32'd0);
    checkOutput("post_rst_wait", 32'(wait_s), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hps_pio_cmd_bridge.md
# hps_pio_cmd_bridge

Parametrised bridge between the HPS parallel-I/O exports (instruction word, 2-bit action/strobe, 2-bit wait/status, result word) and the FPGA coprocessor core. It replaces the single-register, software-paced instruction handshake with buffered command and result FIFOs of configurable width and depth. Both FIFOs use a formal four-phase handshake on the PIO side and valid/ready on the coprocessor side. It sits between the `soc_system` PIO exports and the filter coprocessor in the top level.

## Interface
- `DATA_W`, 32: width of instruction and result words.
- `CMD_DEPTH`, 8: command FIFO depth; power of two, ≥2.
- `RES_DEPTH`, 4: result FIFO depth; power of two, ≥2.
- `SYNC_IN`, 0: 0 = `act_ins` sampled directly; 1 = `act_ins` passes a 2-flop synchroniser first.

Ports:
- `clk_clk` in 1: single clock; all logic is rising-edge.
- `reset_reset` in 1: asynchronous, active-high reset.
- `instrucao` in DATA_W: instruction word from the HPS PIO.
- `act_ins` in 2: HPS strobes. [0] = command request, [1] = result acknowledge.
- `wait_s` out 2: status to the HPS. [0] = command acknowledge, [1] = result valid.
- `data` out DATA_W: result word to the HPS PIO.
- `cmd_data` out DATA_W: head of the command FIFO (show-ahead).
- `cmd_valid` out 1: command FIFO not empty.
- `cmd_ready` in 1: coprocessor accepts the head.
- `res_data` in DATA_W: result from the coprocessor.
- `res_valid` in 1: result offered.
- `res_ready` out 1: result FIFO not full.
- `cmd_level` out $clog2(CMD_DEPTH)+1: command FIFO occupancy.
- `res_level` out $clog2(RES_DEPTH)+1: result FIFO occupancy.

## Operation
- Let `a` be `act_ins` after the optional synchroniser.
- Each FIFO uses a register array with read/write pointers one bit wider than the address. Full means the address bits are equal and the MSBs differ; empty means the pointers are equal.

Command FSM (CI_IDLE, CI_ACK):
- In CI_IDLE, when `a[0]`=1 and the FIFO is not full: push `instrucao`, set `wait_s[0]`=1, go to CI_ACK.
- When `a[0]`=1 and the FIFO is full: stay in CI_IDLE with `wait_s[0]`=0. This is back-pressure to software.
- In CI_ACK, when `a[0]`=0: clear `wait_s[0]`, go to CI_IDLE.
- Exactly one push per request high phase, however long `a[0]` is held.

Coprocessor side:
- Command pop occurs when `cmd_valid & cmd_ready`.
- Result push occurs when `res_valid & res_ready`.
- Push is blocked when the FIFO is full, even if a pop happens in the same cycle.
- Pop and push in the same cycle on a non-full, non-empty FIFO are both performed; the level is unchanged.

Result FSM (R_EMPTY, R_PRESENT, R_DRAIN):
- In R_EMPTY, when the result FIFO is not empty: load the `data` register from the head, set `wait_s[1]`=1, go to R_PRESENT.
- In R_PRESENT, when `a[1]`=1: pop the result FIFO, clear `wait_s[1]`, go to R_DRAIN.
- In R_DRAIN, when `a[1]`=0: go to R_EMPTY.
- `data` holds its last loaded value until the next load. It is never overwritten while `wait_s[1]`=1.
- `a[1]`=1 seen in R_EMPTY is ignored; no pop occurs.

Reset mid-operation:
- Pointers, FSMs and the synchroniser clear.
- Queued words are discarded.
- All outputs take their reset values.

## Timing
Reset values:
- `wait_s`=2'b00, `data`=0, `cmd_valid`=0, `res_ready`=1.
- `cmd_level`=0, `res_level`=0.
- `cmd_data` is don't-care while `cmd_valid`=0.

Latencies, with SYNC_IN=0 (SYNC_IN=1 adds 2 cycles to every `act_ins`-driven response):
- `a[0]` rising sampled at edge N: the push occurs at N; `wait_s[0]`=1, `cmd_valid`=1 and `cmd_level`+1 are visible after N.
- `a[0]` falling sampled at edge N: `wait_s[0]`=0 after N.
- A result pushed at edge N into an empty FIFO in R_EMPTY gives `data` and `wait_s[1]`=1 after N+1.
- `a[1]` rising sampled at edge N: the pop occurs and `wait_s[1]`=0 after N.
- After a result falling `a[1]` at edge N, the next queued result is presented after N+1.

Output timing:
- `cmd_valid`, `res_ready`, `cmd_level` and `res_level` are registered state, updated on the push/pop edge.
- `cmd_data` is the combinational read of the head entry.

## Test plan
- **Reset:** assert `reset_reset` asynchronously mid-cycle with 3 commands queued -> outputs go immediately to their reset values; `cmd_level`=0.
- **Single command:** write `instrucao`=32'hA5A5_0001, `act_ins`=2'b01 held for 10 cycles, then release -> exactly one push; `cmd_data`=32'hA5A5_0001; `wait_s[0]` rises one cycle after the request and falls one cycle after release.
- **Full back-pressure:** `cmd_ready`=0, issue 9 handshakes with CMD_DEPTH=8 -> 8 are acknowledged and the 9th holds `wait_s[0]`=0. Pulse `cmd_ready` once -> the 9th is acknowledged the next cycle; `cmd_level` returns to 8.
- **Result stream:** push results 1, 2, 3 back-to-back, then perform HPS ack cycles -> `data` shows 1, 2, 3 in order; each is stable while `wait_s[1]`=1; `res_level` ends at 0.
- **Result FIFO full and simultaneous events:** with RES_DEPTH=4 and 4 results queued -> `res_ready`=0. Push a command and pop a result in the same cycle -> both occur and both levels update correctly.
- **Synchroniser:** SYNC_IN=1 with the single-command stimulus -> `wait_s[0]` is delayed by exactly 2 extra cycles.
